// File: rtl/square_stream_checker.sv
// Purpose: self-check of a free-running squarer stream against squares rebuilt by odd-number accumulation (optional CHECK_DUMP_EN adds first-mismatch capture).
// Latency: every output is registered and reflects a sample one cycle after its valid edge.
// Backpressure: none; the checker always accepts, and in_valid gaps simply hold the state.
module square_stream_checker #(
    parameter int N           = 30,
    parameter int W           = 16,
    parameter int NUM_SAMPLES = 1024
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic         fail,
    output logic [7:0]   err_cnt,
`ifdef CHECK_DUMP_EN
    output logic [N-1:0] dump_idx,
    output logic [W-1:0] dump_exp,
    output logic [W-1:0] dump_got,
`endif
    output logic [N-1:0] sample_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [N-1:0] LAST_IDX = N'(NUM_SAMPLES - 1);

    state_t       state, state_nxt;
    logic [N-1:0] sq;
    logic [N-1:0] odd;
    logic [W-1:0] exp_dat;
    logic         consume;
    logic         mism;
    logic         last;

    assign exp_dat = sq[N-1:N-W];
    // The start cycle always wins, so a sample presented alongside start is dropped.
    assign consume = (state == S_RUN) && in_valid && !start;
    assign mism    = consume && (in_data != exp_dat);
    assign last    = consume && (sample_cnt == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = S_RUN;
        end else begin
            case (state)
                S_RUN:   if (last) state_nxt = S_DONE;
                default: state_nxt = state;
            endcase
        end
    end

    always_comb begin
        busy = (state == S_RUN);
        done = (state == S_DONE);
        pass = (state == S_DONE) && !fail;
    end

    // sq(k+1) = sq(k) + (2k+1); truncation to N bits mirrors the squarer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sq         <= '0;
            odd        <= N'(1);
            sample_cnt <= '0;
            err_cnt    <= '0;
            fail       <= 1'b0;
        end else if (start) begin
            sq         <= '0;
            odd        <= N'(1);
            sample_cnt <= '0;
            err_cnt    <= '0;
            fail       <= 1'b0;
        end else if (consume) begin
            sq         <= sq + odd;
            odd        <= odd + N'(2);
            sample_cnt <= sample_cnt + N'(1);
            if (mism) begin
                fail <= 1'b1;
                if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            end
        end
    end

`ifdef CHECK_DUMP_EN
    // fail is still clear during the first mismatch of a run, which gates the capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dump_idx <= '0;
            dump_exp <= '0;
            dump_got <= '0;
        end else if (start) begin
            dump_idx <= '0;
            dump_exp <= '0;
            dump_got <= '0;
        end else if (mism && !fail) begin
            dump_idx <= sample_cnt;
            dump_exp <= exp_dat;
            dump_got <= in_data;
        end
    end
`endif

endmodule
